// File: rtl/baccarat_match_fsm_pkg.sv
// Shared types and encodings for the baccarat match sequencer.
package baccarat_match_fsm_pkg;

  // Controller states, in deal order.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CLEAR  = 4'd1,
    S_P1     = 4'd2,
    S_D1     = 4'd3,
    S_P2     = 4'd4,
    S_D2     = 4'd5,
    S_EVAL   = 4'd6,
    S_P3     = 4'd7,
    S_BANKER = 4'd8,
    S_D3     = 4'd9,
    S_RESULT = 4'd10,
    S_HOLD   = 4'd11,
    S_DONE   = 4'd12
  } state_t;

  // Light / result encodings: {player, dealer}; both set means a tie.
  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b10;
  localparam logic [1:0] RES_DEALER = 2'b01;
  localparam logic [1:0] RES_TIE    = 2'b11;

  // Compare two hand scores and return the light encoding of the winner.
  function automatic logic [1:0] score_result(input logic [3:0] p, input logic [3:0] d);
    if (p > d)      return RES_PLAYER;
    else if (p < d) return RES_DEALER;
    else            return RES_TIE;
  endfunction

endpackage

// File: rtl/banker_rule.sv
// Banker third-card table, applied once the player has drawn a third card.
module banker_rule (
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  // Decode the draw decision from banker score and player third card.
  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (pcard3 != 4'd8);
      4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          draw = 1'b0;  // 7 always stands; >9 out of contract
    endcase
  end

endmodule

// File: rtl/baccarat_match_fsm.sv
// Match-level baccarat controller: deals ROUNDS hands, tallies the results
// and reports the overall match winner. Moore outputs decoded from state.
module baccarat_match_fsm
  import baccarat_match_fsm_pkg::*;
#(
  parameter int ROUNDS = 5,
  parameter int CNT_W  = 4
) (
  input  logic             slow_clock,
  input  logic             reset,
  input  logic             start,
  input  logic             next_round,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  input  logic [3:0]       pcard3,
  output logic             clear_hands,
  output logic             load_pcard1,
  output logic             load_pcard2,
  output logic             load_pcard3,
  output logic             load_dcard1,
  output logic             load_dcard2,
  output logic             load_dcard3,
  output logic             player_win_light,
  output logic             dealer_win_light,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties,
  output logic [3:0]       round_count,
  output logic             match_done,
  output logic             match_player,
  output logic             match_dealer
);

  localparam logic [3:0]       ROUNDS_4 = 4'(ROUNDS);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [1:0]       lights_reg;
  logic [CNT_W-1:0] pwins_reg, dwins_reg, ties_reg;
  logic [3:0]       round_reg;
  logic             banker_draw;
  logic [1:0]       hand_result;
  logic [1:0]       match_result;

  banker_rule u_banker_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (banker_draw)
  );

  assign hand_result = score_result(pscore, dscore);

  // Next-state selection: fixed deal path with branches at EVAL and BANKER.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_CLEAR;
      S_CLEAR:  state_next = S_P1;
      S_P1:     state_next = S_D1;
      S_D1:     state_next = S_P2;
      S_P2:     state_next = S_D2;
      S_D2:     state_next = S_EVAL;
      S_EVAL: begin
        if (pscore >= 4'd8 || dscore >= 4'd8) state_next = S_RESULT;  // natural
        else if (pscore <= 4'd5)              state_next = S_P3;
        else if (dscore <= 4'd5)              state_next = S_D3;
        else                                  state_next = S_RESULT;
      end
      S_P3:     state_next = S_BANKER;
      S_BANKER: state_next = banker_draw ? S_D3 : S_RESULT;
      S_D3:     state_next = S_RESULT;
      S_RESULT: state_next = S_HOLD;
      S_HOLD: begin
        // Final hand skips the next_round handshake and goes straight to DONE.
        if (round_reg == ROUNDS_4) state_next = S_DONE;
        else if (next_round)       state_next = S_CLEAR;
      end
      S_DONE:   if (start) state_next = S_CLEAR;
      default:  state_next = S_IDLE;
    endcase
  end

  // State register, lights and saturating tallies.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      lights_reg <= RES_NONE;
      pwins_reg  <= '0;
      dwins_reg  <= '0;
      ties_reg   <= '0;
      round_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DONE && start) begin
        pwins_reg <= '0;
        dwins_reg <= '0;
        ties_reg  <= '0;
        round_reg <= '0;
      end
      if (state_next == S_CLEAR) begin
        lights_reg <= RES_NONE;
      end
      if (state_reg == S_RESULT) begin
        lights_reg <= hand_result;
        round_reg  <= round_reg + 4'd1;
        case (hand_result)
          RES_PLAYER: if (pwins_reg != CNT_MAX) pwins_reg <= pwins_reg + CNT_ONE;
          RES_DEALER: if (dwins_reg != CNT_MAX) dwins_reg <= dwins_reg + CNT_ONE;
          default:    if (ties_reg  != CNT_MAX) ties_reg  <= ties_reg  + CNT_ONE;
        endcase
      end
    end
  end

  // Match verdict from the tallies, only presented while in DONE.
  always_comb begin
    match_result = RES_NONE;
    if (state_reg == S_DONE) begin
      if (pwins_reg > dwins_reg)      match_result = RES_PLAYER;
      else if (pwins_reg < dwins_reg) match_result = RES_DEALER;
      else                            match_result = RES_TIE;
    end
  end

  assign clear_hands      = (state_reg == S_CLEAR);
  assign load_pcard1      = (state_reg == S_P1);
  assign load_dcard1      = (state_reg == S_D1);
  assign load_pcard2      = (state_reg == S_P2);
  assign load_dcard2      = (state_reg == S_D2);
  assign load_pcard3      = (state_reg == S_P3);
  assign load_dcard3      = (state_reg == S_D3);
  assign match_done       = (state_reg == S_DONE);
  assign player_win_light = lights_reg[1];
  assign dealer_win_light = lights_reg[0];
  assign player_wins      = pwins_reg;
  assign dealer_wins      = dwins_reg;
  assign ties             = ties_reg;
  assign round_count      = round_reg;
  assign match_player     = match_result[1];
  assign match_dealer     = match_result[0];

endmodule

// File: tb/tb_baccarat_match_fsm.sv
// Directed bench: a 3-hand match instance and a 2-bit-tally instance.
module tb_baccarat_match_fsm;

  logic       slow_clock;
  logic       reset_a, reset_b;
  logic       start, next_round;
  logic [3:0] pscore, dscore, pcard3;
  logic       sel;

  logic       clr_a, p1_a, p2_a, p3_a, d1_a, d2_a, d3_a, pl_a, dl_a, md_a, mp_a, mdl_a;
  logic [3:0] pw_a, dw_a, ti_a, rc_a;
  logic       clr_b, p1_b, p2_b, p3_b, d1_b, d2_b, d3_b, pl_b, dl_b, md_b, mp_b, mdl_b;
  logic [1:0] pw_b, dw_b, ti_b;
  logic [3:0] rc_b;

  int tests;
  int failures;

  baccarat_match_fsm #(.ROUNDS(3), .CNT_W(4)) dut_a (
    .slow_clock(slow_clock), .reset(reset_a), .start(start), .next_round(next_round),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .clear_hands(clr_a), .load_pcard1(p1_a), .load_pcard2(p2_a), .load_pcard3(p3_a),
    .load_dcard1(d1_a), .load_dcard2(d2_a), .load_dcard3(d3_a),
    .player_win_light(pl_a), .dealer_win_light(dl_a),
    .player_wins(pw_a), .dealer_wins(dw_a), .ties(ti_a), .round_count(rc_a),
    .match_done(md_a), .match_player(mp_a), .match_dealer(mdl_a)
  );

  baccarat_match_fsm #(.ROUNDS(5), .CNT_W(2)) dut_b (
    .slow_clock(slow_clock), .reset(reset_b), .start(start), .next_round(next_round),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .clear_hands(clr_b), .load_pcard1(p1_b), .load_pcard2(p2_b), .load_pcard3(p3_b),
    .load_dcard1(d1_b), .load_dcard2(d2_b), .load_dcard3(d3_b),
    .player_win_light(pl_b), .dealer_win_light(dl_b),
    .player_wins(pw_b), .dealer_wins(dw_b), .ties(ti_b), .round_count(rc_b),
    .match_done(md_b), .match_player(mp_b), .match_dealer(mdl_b)
  );

  // Observation mux: sel picks which instance the checks look at.
  logic [6:0] obs_strobes;  // {clear, p1, d1, p2, d2, p3, d3}
  logic [1:0] obs_lights, obs_match;
  logic [3:0] obs_pw, obs_dw, obs_ti, obs_rc;
  logic       obs_done;
  assign obs_strobes = sel ? {clr_b, p1_b, d1_b, p2_b, d2_b, p3_b, d3_b}
                           : {clr_a, p1_a, d1_a, p2_a, d2_a, p3_a, d3_a};
  assign obs_lights  = sel ? {pl_b, dl_b} : {pl_a, dl_a};
  assign obs_match   = sel ? {mp_b, mdl_b} : {mp_a, mdl_a};
  assign obs_pw      = sel ? {2'b00, pw_b} : pw_a;
  assign obs_dw      = sel ? {2'b00, dw_b} : dw_a;
  assign obs_ti      = sel ? {2'b00, ti_b} : ti_a;
  assign obs_rc      = sel ? rc_b : rc_a;
  assign obs_done    = sel ? md_b : md_a;

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  // Kick a hand with start or next_round, follow it to HOLD, check its shape.
  task automatic run_hand(input string tag, input bit use_start,
                          input logic [3:0] ps, input logic [3:0] ds, input logic [3:0] pc3,
                          input int exp_len, input bit exp_p3, input bit exp_d3,
                          input logic [1:0] exp_lights);
    int i_p1, i_d1, i_p2, i_d2, i_p3, i_d3, max_on, len;
    logic [3:0] prev;
    bit got;
    pscore = ps; dscore = ds; pcard3 = pc3;
    if (use_start) start = 1'b1; else next_round = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (obs_strobes[6]) begin got = 1'b1; break; end
    end
    start = 1'b0; next_round = 1'b0;
    check({tag, " accept"}, 32'(got), 32'd1);
    if (!got) return;
    check({tag, " lights_clr"}, 32'(obs_lights), 32'd0);
    prev = obs_rc;
    i_p1 = -1; i_d1 = -1; i_p2 = -1; i_d2 = -1; i_p3 = -1; i_d3 = -1;
    max_on = $countones(obs_strobes);
    len = 0;
    for (int c = 1; c < 20; c++) begin
      tick();
      if (obs_rc != prev) begin len = c; break; end
      if ($countones(obs_strobes) > max_on) max_on = $countones(obs_strobes);
      if (obs_strobes[5]) i_p1 = c;
      if (obs_strobes[4]) i_d1 = c;
      if (obs_strobes[3]) i_p2 = c;
      if (obs_strobes[2]) i_d2 = c;
      if (obs_strobes[1]) i_p3 = c;
      if (obs_strobes[0]) i_d3 = c;
    end
    $display("[TB] hand %s: len=%0d p3@%0d d3@%0d lights=%b", tag, len, i_p3, i_d3, obs_lights);
    check({tag, " len"}, 32'(len), 32'(exp_len));
    check({tag, " deal_order"}, 32'(i_p1 + i_d1 * 16 + i_p2 * 256 + i_d2 * 4096), 32'h4321);
    check({tag, " p3_idx"}, 32'(i_p3), exp_p3 ? 32'd6 : 32'hffffffff);
    check({tag, " d3_idx"}, 32'(i_d3), exp_d3 ? (exp_p3 ? 32'd8 : 32'd6) : 32'hffffffff);
    check({tag, " one_hot"}, 32'(max_on), 32'd1);
    check({tag, " lights"}, 32'(obs_lights), 32'(exp_lights));
  endtask

  initial begin
    bit seen;
    tests = 0; failures = 0;
    sel = 1'b0;
    reset_a = 1'b1; reset_b = 1'b1;
    start = 1'b0; next_round = 1'b0;
    pscore = 4'd0; dscore = 4'd0; pcard3 = 4'd0;
    repeat (3) tick();
    reset_a = 1'b0;

    // Reset state.
    check("rst strobes", 32'(obs_strobes), 32'd0);
    check("rst lights", 32'(obs_lights), 32'd0);
    check("rst tallies", 32'({obs_pw, obs_dw, obs_ti, obs_rc}), 32'd0);
    check("rst done", 32'({obs_done, obs_match}), 32'd0);

    // next_round is ignored in IDLE.
    next_round = 1'b1;
    tick(); tick();
    next_round = 1'b0;
    check("idle ignores next_round", 32'(obs_strobes), 32'd0);

    // Match 1 (ROUNDS=3): player, player, dealer.
    run_hand("natural", 1'b1, 4'd8, 4'd5, 4'd0, 7, 1'b0, 1'b0, 2'b10);
    check("A tallies", 32'({obs_pw, obs_dw, obs_ti, obs_rc}), 32'h1001);
    check("A match gated", 32'({obs_done, obs_match}), 32'd0);
    repeat (3) tick();
    check("hold waits", 32'({obs_strobes, obs_rc}), 32'h001);
    check("hold lights", 32'(obs_lights), 32'b10);

    run_hand("stand_bdraw", 1'b0, 4'd6, 4'd2, 4'd0, 8, 1'b0, 1'b1, 2'b10);
    check("B tallies", 32'({obs_pw, obs_dw, obs_ti, obs_rc}), 32'h2002);

    run_hand("both_draw", 1'b0, 4'd3, 4'd6, 4'd6, 10, 1'b1, 1'b1, 2'b01);
    check("C tallies", 32'({obs_pw, obs_dw, obs_ti, obs_rc}), 32'h2103);
    check("C not done yet", 32'(obs_done), 32'd0);
    tick();
    check("match1 done", 32'(obs_done), 32'd1);
    check("match1 winner", 32'(obs_match), 32'b10);

    // Match 2 started from DONE with start held until accepted.
    run_hand("p_draw_b_stand", 1'b1, 4'd3, 4'd3, 4'd8, 9, 1'b1, 1'b0, 2'b11);
    check("D tallies cleared", 32'({obs_pw, obs_dw, obs_ti, obs_rc}), 32'h0011);
    run_hand("b_stand5", 1'b0, 4'd4, 4'd5, 4'd3, 9, 1'b1, 1'b0, 2'b01);
    check("F tallies", 32'({obs_pw, obs_dw, obs_ti, obs_rc}), 32'h0112);

    // Reset asserted while in P3.
    pscore = 4'd3; dscore = 4'd6; pcard3 = 4'd2;
    next_round = 1'b1;
    tick();
    next_round = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (obs_strobes[1]) begin seen = 1'b1; break; end
      tick();
    end
    check("reached P3", 32'(seen), 32'd1);
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    $display("[TB] reset mid-P3: strobes=%b lights=%b", obs_strobes, obs_lights);
    check("midrst strobes", 32'(obs_strobes), 32'd0);
    check("midrst lights", 32'(obs_lights), 32'd0);
    check("midrst tallies", 32'({obs_pw, obs_dw, obs_ti, obs_rc}), 32'd0);
    tick();
    check("midrst idle", 32'({obs_strobes, obs_done}), 32'd0);

    run_hand("tie77", 1'b1, 4'd7, 4'd7, 4'd0, 7, 1'b0, 1'b0, 2'b11);
    check("E tallies", 32'({obs_pw, obs_dw, obs_ti, obs_rc}), 32'h0011);

    // Second instance: ROUNDS=5, CNT_W=2, five player naturals.
    reset_a = 1'b1;
    sel = 1'b1;
    tick();
    reset_b = 1'b0;
    for (int h = 1; h <= 5; h++) begin
      run_hand("sat", h == 1, 4'd9, 4'd0, 4'd0, 7, 1'b0, 1'b0, 2'b10);
      check("sat pwins", 32'(obs_pw), (h < 3) ? 32'(h) : 32'd3);
    end
    check("sat rounds", 32'(obs_rc), 32'd5);
    tick();
    check("sat done", 32'({obs_done, obs_match}), 32'b110);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
